// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Hazard detection beside the ID stage of the 5-stage MIPS pipeline.
// It stalls for load-use hazards, freezes the front end during multi-cycle EX
// operations (mul/div), and raises branch flushes. It also keeps saturating
// performance counters for stall cycles and flush cycles.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   ID_EX_rt, ID_EX_mem_read    destination and load flag of the EX instruction
//   ID_EX_multi_start           one-cycle pulse when a multi-cycle op enters EX
//   IF_ID_rs, IF_ID_rt          sources of the ID instruction
//   IF_ID_uses_rt               ID instruction really reads rt
//   branch, equal               branch kind (00/01 beq/10 bne/11 jump), ID compare
//   perf_clr                    synchronous clear of both counters
//   pc_write, IF_ID_write       front-end update enables
//   ID_EX_write                 ID/EX update enable (low only in multi hold)
//   mux_hz_unit                 1 passes ID control, 0 injects a bubble
//   flush                       squash IF/ID
//   busy                        FSM not idle (stall cycles 2..N)
//   stall_cycles, flush_count   saturating performance counters
module hazard_control_unit #(
    parameter int unsigned REG_W         = 5,
    parameter int unsigned LOAD_LATENCY  = 1,
    parameter int unsigned MULTI_LATENCY = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] ID_EX_rt,
    input  logic             ID_EX_mem_read,
    input  logic             ID_EX_multi_start,
    input  logic [REG_W-1:0] IF_ID_rs,
    input  logic [REG_W-1:0] IF_ID_rt,
    input  logic             IF_ID_uses_rt,
    input  logic [1:0]       branch,
    input  logic             equal,
    input  logic             perf_clr,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             mux_hz_unit,
    output logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned MAX_LAT = (LOAD_LATENCY > MULTI_LATENCY) ? LOAD_LATENCY : MULTI_LATENCY;
    localparam int unsigned DC_W    = $clog2(MAX_LAT) + 1;

    localparam logic [DC_W-1:0] LOAD_RELOAD  = DC_W'(LOAD_LATENCY - 1);
    localparam logic [DC_W-1:0] MULTI_RELOAD = DC_W'(MULTI_LATENCY - 1);
    localparam logic [DC_W-1:0] DC_ONE       = DC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_LOAD_STALL = 2'd1,
        S_MULTI_HOLD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [DC_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu_c;
    logic multi_c;
    logic taken_c;
    logic load_stall_c;
    logic multi_hold_c;

    // Hazard requests are masked while in reset so every output shows its reset value.
    assign lu_c = rst_n && ID_EX_mem_read && (ID_EX_rt != '0) &&
                  ((IF_ID_rs == ID_EX_rt) || (IF_ID_uses_rt && (IF_ID_rt == ID_EX_rt)));
    assign multi_c = rst_n && ID_EX_multi_start;

    // Raw branch decision from the ID comparator.
    assign taken_c = ((branch == 2'b01) &&  equal) ||
                     ((branch == 2'b10) && !equal) ||
                      (branch == 2'b11);

    // State register and down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the first stall cycle is decided combinationally in IDLE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_stall_c = 1'b0;
        multi_hold_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (multi_c) begin
                    multi_hold_c = 1'b1;
                    if (MULTI_LATENCY > 1) begin
                        state_d = S_MULTI_HOLD;
                        cnt_d   = MULTI_RELOAD;
                    end
                end else if (lu_c) begin
                    load_stall_c = 1'b1;
                    if (LOAD_LATENCY > 1) begin
                        state_d = S_LOAD_STALL;
                        cnt_d   = LOAD_RELOAD;
                    end
                end
            end
            S_LOAD_STALL: begin
                load_stall_c = 1'b1;
                cnt_d        = cnt_q - DC_ONE;
                if (cnt_q == DC_ONE) begin
                    state_d = S_IDLE;
                end
            end
            S_MULTI_HOLD: begin
                multi_hold_c = 1'b1;
                cnt_d        = cnt_q - DC_ONE;
                if (cnt_q == DC_ONE) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pipeline control; a branch is re-evaluated after any stall, so flush is gated.
    assign pc_write    = !(load_stall_c || multi_hold_c);
    assign IF_ID_write = !(load_stall_c || multi_hold_c);
    assign ID_EX_write = !multi_hold_c;
    assign mux_hz_unit = !load_stall_c;
    assign flush       = taken_c && !load_stall_c && !multi_hold_c;
    assign busy        = (state_q != S_IDLE);

    // Saturating counters; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Testbench for hazard_control_unit (LOAD_LATENCY=2, MULTI_LATENCY=4, CNT_W=2).
// A schedule-queue model predicts every output each cycle; directed tests add
// hand-computed literal expectations.
module tb_hazard_control_unit;

    localparam int unsigned REG_W = 5;
    localparam int unsigned LL    = 2;
    localparam int unsigned ML    = 4;
    localparam int unsigned CW    = 2;
    localparam int          CMAX  = (1 << CW) - 1;

    localparam int K_NONE  = 0;
    localparam int K_LOAD  = 1;
    localparam int K_MULTI = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] ex_rt, id_rs, id_rt;
    logic             mem_read, multi, uses_rt, equal, perf_clr;
    logic [1:0]       branch;
    logic             pc_write, IF_ID_write, ID_EX_write, mux_hz_unit, flush, busy;
    logic [CW-1:0]    stall_cycles, flush_count;

    int tests = 0;
    int fails = 0;

    int sched[$];
    int m_stall = 0;
    int m_flush = 0;

    int lowcnt, busycnt, idexcnt, flcnt;

    hazard_control_unit #(
        .REG_W(REG_W), .LOAD_LATENCY(LL), .MULTI_LATENCY(ML), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_EX_rt(ex_rt), .ID_EX_mem_read(mem_read), .ID_EX_multi_start(multi),
        .IF_ID_rs(id_rs), .IF_ID_rt(id_rt), .IF_ID_uses_rt(uses_rt),
        .branch(branch), .equal(equal), .perf_clr(perf_clr),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
        .mux_hz_unit(mux_hz_unit), .flush(flush), .busy(busy),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a hazard schedules N cycles of its kind; inputs are only looked at when idle.
    always @(negedge clk) begin
        int  cur;
        int  fresh;
        int  raw;
        int  lu;
        int  e_pc, e_idex, e_mux, e_flush, e_busy;
        raw = ((branch == 2'b01 && equal) || (branch == 2'b10 && !equal) ||
               (branch == 2'b11)) ? 1 : 0;
        if (rst_n !== 1'b1) begin
            sched.delete();
            m_stall = 0;
            m_flush = 0;
            cur   = K_NONE;
            fresh = 0;
        end else begin
            fresh = 0;
            lu = (mem_read && ex_rt != 0 &&
                  (id_rs == ex_rt || (uses_rt && id_rt == ex_rt))) ? 1 : 0;
            if (sched.size() == 0) begin
                if (multi) begin
                    for (int i = 0; i < int'(ML); i++) sched.push_back(K_MULTI);
                    fresh = 1;
                end else if (lu != 0) begin
                    for (int i = 0; i < int'(LL); i++) sched.push_back(K_LOAD);
                    fresh = 1;
                end
            end
            cur = (sched.size() != 0) ? sched.pop_front() : K_NONE;
        end
        e_pc    = (cur == K_NONE) ? 1 : 0;
        e_idex  = (cur == K_MULTI) ? 0 : 1;
        e_mux   = (cur == K_LOAD) ? 0 : 1;
        e_flush = (cur == K_NONE) ? raw : 0;
        e_busy  = (cur != K_NONE && fresh == 0) ? 1 : 0;
        chk("pc_write",     int'(pc_write),     e_pc);
        chk("IF_ID_write",  int'(IF_ID_write),  e_pc);
        chk("ID_EX_write",  int'(ID_EX_write),  e_idex);
        chk("mux_hz_unit",  int'(mux_hz_unit),  e_mux);
        chk("flush",        int'(flush),        e_flush);
        chk("busy",         int'(busy),         e_busy);
        chk("stall_cycles", int'(stall_cycles), m_stall);
        chk("flush_count",  int'(flush_count),  m_flush);
        if (rst_n === 1'b1) begin
            if (perf_clr) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (e_pc == 0 && m_stall < CMAX) m_stall++;
                if (e_flush != 0 && m_flush < CMAX) m_flush++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        mem_read = 1'b0; multi = 1'b0; uses_rt = 1'b0;
        ex_rt = '0; id_rs = '0; id_rt = '0;
        branch = 2'b00; equal = 1'b0;
    endtask

    task automatic clear_obs();
        lowcnt = 0; busycnt = 0; idexcnt = 0; flcnt = 0;
    endtask

    task automatic obs();
        @(negedge clk);
        if (!pc_write)    lowcnt++;
        if (busy)         busycnt++;
        if (!ID_EX_write) idexcnt++;
        if (flush)        flcnt++;
    endtask

    task automatic clr();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end by t=100000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        perf_clr = 1'b0;
        set_idle();
        @(negedge clk);
        chk("rst_pc_write", int'(pc_write), 1);
        chk("rst_id_ex_write", int'(ID_EX_write), 1);
        chk("rst_mux", int'(mux_hz_unit), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_stall_cnt", int'(stall_cycles), 0);
        tick(); tick();
        rst_n = 1'b1;

        // Single load-use hazard on rs: 2 stall cycles, busy only in the 2nd.
        clr();
        clear_obs();
        mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        obs(); tick();
        set_idle();
        repeat (3) begin obs(); tick(); end
        chk("t1_stall_len", lowcnt, 2);
        chk("t1_busy_cycles", busycnt, 1);
        @(negedge clk);
        chk("t1_stall_count", int'(stall_cycles), 2);

        // No hazard via r0 or an unused rt; then a real rt hazard.
        tick();
        clear_obs();
        mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; uses_rt = 1'b1;
        obs(); tick();
        ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; uses_rt = 1'b0;
        obs(); tick();
        chk("t2_no_stall", lowcnt, 0);
        uses_rt = 1'b1;
        obs(); tick();
        set_idle();
        obs(); tick();
        obs(); tick();
        chk("t2_rt_stall", lowcnt, 2);

        // Multi-cycle hold with a taken beq pending; flush only after the hold.
        clr();
        clear_obs();
        multi = 1'b1; branch = 2'b01; equal = 1'b1;
        obs(); tick();
        multi = 1'b0;
        repeat (3) begin obs(); tick(); end
        chk("t3_hold_len", idexcnt, 4);
        chk("t3_flush_in_hold", flcnt, 0);
        @(negedge clk);
        chk("t3_flush_after", int'(flush), 1);
        chk("t3_pc_back", int'(pc_write), 1);
        tick();
        set_idle();
        @(negedge clk);
        chk("t3_flush_count", int'(flush_count), 1);

        // Back-to-back load-use: hazard still present when the first stall ends.
        tick();
        clr();
        clear_obs();
        mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        repeat (3) begin obs(); tick(); end
        set_idle();
        repeat (3) begin obs(); tick(); end
        chk("t4_b2b_len", lowcnt, 4);
        chk("t4_b2b_busy", busycnt, 2);

        // Reset asserted in cycle 2 of the multi hold.
        clear_obs();
        multi = 1'b1;
        obs(); tick();
        multi = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_pc", int'(pc_write), 1);
        chk("t5_rst_if_id", int'(IF_ID_write), 1);
        chk("t5_rst_id_ex", int'(ID_EX_write), 1);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_cnt", int'(stall_cycles), 0);
        tick();
        rst_n = 1'b1;
        clear_obs();
        repeat (4) begin obs(); tick(); end
        chk("t5_no_resume", lowcnt, 0);

        // Saturation at 3 after 5 stall cycles, then clear while still stalled.
        clr();
        mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        repeat (5) tick();
        @(negedge clk);
        chk("t6_saturated", int'(stall_cycles), 3);
        chk("t6_still_stalled", int'(pc_write), 0);
        set_idle();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        @(negedge clk);
        chk("t6_cleared", int'(stall_cycles), 0);

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
